// File: rtl/vid_pattern_gen.sv
// Video timing and test-pattern generator: sync/blank/daten with per-signal polarity, RGB test patterns.
// Latency: outputs registered one cycle after the counters; no backpressure (free-running pixel clock).
// Optional build macro: VID_SCROLL_EN (patterns scroll left one pixel per frame).
module vid_pattern_gen #(
  parameter int CW       = 16,
  parameter int SW       = 8,
  parameter int DW       = 8,
  parameter int BAR_LOG2 = 4,
  parameter int CHK_LOG2 = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ctrl_ven,
  input  logic            ctrl_hsync_pol,
  input  logic            ctrl_vsync_pol,
  input  logic            ctrl_blank_pol,
  input  logic            ctrl_daten_pol,
  input  logic [SW-1:0]   Thsync,
  input  logic [SW-1:0]   Thgdel,
  input  logic [CW-1:0]   Thgate,
  input  logic [CW-1:0]   Thlen,
  input  logic [SW-1:0]   Tvsync,
  input  logic [SW-1:0]   Tvgdel,
  input  logic [CW-1:0]   Tvgate,
  input  logic [CW-1:0]   Tvlen,
  input  logic [1:0]      mode,
  input  logic [3*DW-1:0] fill_rgb,
  output logic            eoh,
  output logic            eov,
  output logic            hsync,
  output logic            vsync,
  output logic            blank,
  output logic            daten,
  output logic [3*DW-1:0] pdata
);

  localparam int CW1 = CW + 1;
  localparam int XW0 = (DW > BAR_LOG2 + 3) ? DW : BAR_LOG2 + 3;
  localparam int XW  = (XW0 > CHK_LOG2 + 1) ? XW0 : CHK_LOG2 + 1;

  typedef enum logic [1:0] {H_SYNC, H_GDEL, H_GATE, H_FP} h_state_t;
  typedef enum logic [1:0] {V_SYNC, V_GDEL, V_GATE, V_FP} v_state_t;

  logic [SW-1:0] sh_thsync, sh_thgdel, sh_tvsync, sh_tvgdel;
  logic [CW-1:0] sh_thgate, sh_thlen, sh_tvgate, sh_tvlen;
  logic [1:0]    sh_mode;
  logic          load_pend, en_q;
  logic [CW-1:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;

  logic [CW-1:0]  hlen, vlen;
  logic [CW1-1:0] h_s1, h_s2, h_s3, v_s1, v_s2, v_s3;
  logic           h_end, v_end, fwrap, visible, y_chk;
  h_state_t       h_st;
  v_state_t       v_st;
  logic [XW-1:0]  xs;
  logic [2:0]     bar_c;
  logic [3*DW-1:0] pat;

`ifdef VID_SCROLL_EN
  logic [CW-1:0] offset;

  always_ff @(posedge clk) begin
    if (!rst_n || !ctrl_ven) offset <= '0;
    else if (fwrap)          offset <= offset + CW'(1);
  end

  assign xs = XW'(hcnt - h_s2[CW-1:0] + offset);
`else
  assign xs = XW'(hcnt - h_s2[CW-1:0]);
`endif

  always_comb begin
    hlen  = (sh_thlen < CW'(2)) ? CW'(2) : sh_thlen;
    vlen  = (sh_tvlen < CW'(2)) ? CW'(2) : sh_tvlen;
    h_s1  = CW1'(sh_thsync);
    h_s2  = h_s1 + CW1'(sh_thgdel);
    h_s3  = h_s2 + CW1'(sh_thgate);
    v_s1  = CW1'(sh_tvsync);
    v_s2  = v_s1 + CW1'(sh_tvgdel);
    v_s3  = v_s2 + CW1'(sh_tvgate);
    h_end = hcnt >= hlen - CW'(1);
    v_end = vcnt >= vlen - CW'(1);
    fwrap = en_q && h_end && v_end;

    h_st = H_FP;
    if      (CW1'(hcnt) < h_s1) h_st = H_SYNC;
    else if (CW1'(hcnt) < h_s2) h_st = H_GDEL;
    else if (CW1'(hcnt) < h_s3) h_st = H_GATE;
    v_st = V_FP;
    if      (CW1'(vcnt) < v_s1) v_st = V_SYNC;
    else if (CW1'(vcnt) < v_s2) v_st = V_GDEL;
    else if (CW1'(vcnt) < v_s3) v_st = V_GATE;
    visible = (h_st == H_GATE) && (v_st == V_GATE);

    // A fresh enable holds (0,0) for one cycle so the first output lands two edges later.
    hcnt_nxt = '0;
    vcnt_nxt = '0;
    if (ctrl_ven && en_q) begin
      if (h_end) vcnt_nxt = v_end ? '0 : vcnt + CW'(1);
      else begin
        hcnt_nxt = hcnt + CW'(1);
        vcnt_nxt = vcnt;
      end
    end

    y_chk = |(((vcnt - v_s2[CW-1:0]) >> CHK_LOG2) & CW'(1));
    bar_c = 3'd7 - xs[BAR_LOG2+2:BAR_LOG2];
    case (sh_mode)
      2'd0:    pat = {{DW{bar_c[2]}}, {DW{bar_c[1]}}, {DW{bar_c[0]}}};
      2'd1:    pat = {3{xs[DW-1:0]}};
      2'd2:    pat = {3*DW{xs[CHK_LOG2] ^ y_chk}};
      default: pat = fill_rgb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      en_q      <= 1'b0;
      load_pend <= 1'b1;
      sh_thsync <= '0;
      sh_thgdel <= '0;
      sh_thgate <= '0;
      sh_thlen  <= '0;
      sh_tvsync <= '0;
      sh_tvgdel <= '0;
      sh_tvgate <= '0;
      sh_tvlen  <= '0;
      sh_mode   <= '0;
    end else begin
      hcnt      <= hcnt_nxt;
      vcnt      <= vcnt_nxt;
      en_q      <= ctrl_ven;
      load_pend <= 1'b0;
      if (load_pend || !ctrl_ven || fwrap) begin
        sh_thsync <= Thsync;
        sh_thgdel <= Thgdel;
        sh_thgate <= Thgate;
        sh_thlen  <= Thlen;
        sh_tvsync <= Tvsync;
        sh_tvgdel <= Tvgdel;
        sh_tvgate <= Tvgate;
        sh_tvlen  <= Tvlen;
        sh_mode   <= mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
      blank <= 1'b0;
      daten <= 1'b0;
      eoh   <= 1'b0;
      eov   <= 1'b0;
      pdata <= '0;
    end else if (!en_q) begin
      hsync <= ctrl_hsync_pol;
      vsync <= ctrl_vsync_pol;
      blank <= ~ctrl_blank_pol;
      daten <= ctrl_daten_pol;
      eoh   <= 1'b0;
      eov   <= 1'b0;
      pdata <= '0;
    end else begin
      hsync <= (h_st == H_SYNC) ^ ctrl_hsync_pol;
      vsync <= (v_st == V_SYNC) ^ ctrl_vsync_pol;
      blank <= ~visible ^ ctrl_blank_pol;
      daten <= visible ^ ctrl_daten_pol;
      eoh   <= h_end;
      eov   <= h_end && v_end;
      pdata <= visible ? pat : '0;
    end
  end

endmodule

// File: doc/vid_pattern_gen.md
# vid_pattern_gen

Parametrised video timing and test-pattern generator: successor to the fixed-width pixel generator. It produces hsync/vsync/blank/daten with per-signal polarity, and selectable test patterns on a 3×DW-bit RGB bus. Timing and mode inputs are shadow-registered so they only change at frame boundaries. It sits at the head of the video output path and drives the pixel interface directly.

## Interface
- CW, 16: horizontal/vertical length and gate counter width
- SW, 8: sync-width and gate-delay field width
- DW, 8: bits per colour channel
- BAR_LOG2, 4: colour-bar width = 2^BAR_LOG2 pixels
- CHK_LOG2, 3: checker square size = 2^CHK_LOG2 pixels/lines

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset
- ctrl_ven  in  1  video enable
- ctrl_hsync_pol, ctrl_vsync_pol, ctrl_blank_pol, ctrl_daten_pol  in  1 each  output = internal XOR pol
- Thsync, Thgdel  in  SW  hsync width, horizontal gate delay (pixels)
- Thgate, Thlen  in  CW  visible pixels per line, total pixels per line
- Tvsync, Tvgdel  in  SW  vsync width, vertical gate delay (lines)
- Tvgate, Tvlen  in  CW  visible lines, total lines per frame
- mode  in  2  0 colour bars, 1 ramp, 2 checker, 3 solid
- fill_rgb  in  3*DW  solid colour for mode 3, {R,G,B}
- eoh, eov  out  1  end-of-line / end-of-frame pulses
- hsync, vsync, blank, daten  out  1  timing outputs
- pdata  out  3*DW  pixel data {R,G,B}

## Operation
- Counters hcnt (0..Thlen-1) and vcnt (0..Tvlen-1), both CW bits wide.
- hcnt wraps at Thlen-1. vcnt advances on each wrap and itself wraps at Tvlen-1.
- Horizontal FSM: H_SYNC (hcnt<Thsync), H_GDEL (<Thsync+Thgdel), H_GATE (<Thsync+Thgdel+Thgate), H_FP (rest). The vertical FSM is analogous with the V_* states.
- Visible = H_GATE && V_GATE. daten_int = visible and blank_int = !visible.
- xpix = hcnt-(Thsync+Thgdel) and ypix = vcnt-(Tvsync+Tvgdel), both valid only when visible.
- Patterns (per channel, full scale = all ones):
  - Mode 0: bar = xpix[BAR_LOG2+2:BAR_LOG2] and c = 7-bar; R=c[2], G=c[1], B=c[0].
  - Mode 1: R=G=B=xpix[DW-1:0].
  - Mode 2: white if xpix[CHK_LOG2]^ypix[CHK_LOG2], else black.
  - Mode 3: fill_rgb.
  - pdata = 0 whenever not visible.
- Shadow registers for all T* inputs and mode load:
  - on the cycle the frame wraps (hcnt=Thlen-1 and vcnt=Tvlen-1);
  - while ctrl_ven=0.
- The fill_rgb input is not shadowed.
- Length values Thlen/Tvlen below 2 clamp to 2. If Thsync+Thgdel+Thgate>Thlen, the gate truncates at the wrap. Sums are computed CW+1 bits wide, with no overflow wrap.
- ctrl_ven=0:
  - hcnt and vcnt are forced to 0;
  - hsync, vsync and daten drive their inactive level (=pol);
  - blank drives its active level (=~pol);
  - pdata=0, eoh=eov=0.
- ctrl_ven deasserted mid-frame: counters return to 0 on the next edge. No partial-frame completion.

## Timing
- Reset (rst_n=0 sampled at a clk edge): all counters, shadows and registered outputs are 0. This includes hsync, vsync, blank, daten, eoh, eov and pdata, regardless of the pol inputs.
- Mid-operation reset behaves identically. Shadows reload from the inputs on the first cycle after reset.
- Outputs are registered, with one cycle of latency from the counters. The output at cycle t reflects the counter state at t-1.
- First active cycle:
  - ctrl_ven=1 first sampled at edge N: counters are at (0,0) from N+1.
  - Outputs show the position (0,0) from edge N+2.
- eoh is a one-cycle pulse aligned with the output of hcnt=Thlen-1.
- eov pulses only on the cycle where eoh coincides with vcnt=Tvlen-1.
- Simultaneous shadow load and wrap: the new values govern the first pixel of the next frame, (0,0).
- Frame period = Thlen × Tvlen cycles.

## Configuration
- VID_SCROLL_EN defined:
  - A CW-bit offset register increments by 1 at every frame wrap and is cleared by reset or ctrl_ven=0.
  - The pattern generator uses xpix+offset (mod 2^CW) in modes 0-2, so the patterns scroll left by one pixel per frame.
- VID_SCROLL_EN undefined: offset logic is absent and patterns are static.
- Timing outputs are identical in both builds.

## Test plan
- Reset, then ctrl_ven=1 with all pol=0 and timing Thsync/Thgdel/Thgate/Thlen = 8/12/100/130 and Tvsync/Tvgdel/Tvgate/Tvlen = 1/2/16/22. Required response:
  - hsync high 8 cycles per 130-cycle line;
  - daten high for the output of hcnt 20..119;
  - vsync high for line 0 only;
  - eov every 2860 cycles;
  - 1600 daten cycles per frame.
- Same timing, all pol=1 -> every timing output is the bitwise inverse of scenario 1. pdata is unchanged.
- Mode 0, BAR_LOG2=4 -> xpix 0..15 = {FF,FF,FF}, 16..31 = {FF,FF,00}, 112..127 = 0 (Thgate≥128). Mode 2 with CHK_LOG2=3 -> xpix 8, ypix 0 is white; xpix 8, ypix 8 is black.
- Change Thlen 130→140 and mode 0→1 mid-frame -> the current frame keeps 130-cycle lines. The next frame starts with 140-cycle lines and a ramp where pdata = {xpix,xpix,xpix}.
- Drop ctrl_ven at line 5 mid-line -> next cycle counters are 0. The following output cycle shows blank active, daten/hsync/vsync inactive, pdata=0. Re-enable -> the frame restarts at (0,0) after 2 cycles.
- Assert rst_n=0 mid-frame for 1 cycle -> all outputs are 0 on the next cycle. With VID_SCROLL_EN, mode 1: frame k shows pdata R at xpix 0 = k mod 256.
